// File: rtl/gpio_irq_arbiter.sv
// Purpose: latch rising edges of GPIO_0/GPIO_1/GPIO_E as pending bits and arbitrate them onto one core irq line (B0 > B1 > BE).
// Latency: pin rise to irq_o is 2 cycles (4 with GPIO_IRQ_SYNC_EN defined, which adds a 2-flop synchronizer per pin); readdata 1 cycle after avs_read.
// Backpressure: none on the Avalon side; new edges are held in pending bits until the core acks and the ISR clears them.
module gpio_irq_arbiter #(
  parameter int         W0    = 32,
  parameter int         W1    = 32,
  parameter int         WE    = 8,
  parameter logic [4:0] ID_B0 = 5'd3,
  parameter logic [4:0] ID_B1 = 5'd4,
  parameter logic [4:0] ID_BE = 5'd5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W0-1:0] gpio0_i,
  input  logic [W1-1:0] gpio1_i,
  input  logic [WE-1:0] gpioe_i,
  output logic          irq_o,
  output logic [4:0]    irq_id_o,
  input  logic          irq_ack_i,
  input  logic [4:0]    irq_ack_id_i,
  input  logic [1:0]    avs_address,
  input  logic          avs_read,
  input  logic          avs_write,
  input  logic [31:0]   avs_writedata,
  output logic [31:0]   avs_readdata
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t          state, state_d;
  logic [1:0]      sel, sel_d;
  logic [4:0]      id_d;
  logic [W0-1:0]   g0_s, g0_q, edge0, pend0, clr0;
  logic [W1-1:0]   g1_s, g1_q, edge1, pend1, clr1;
  logic [WE-1:0]   ge_s, ge_q, edgee, pende, clre;
  logic [2:0]      enable;
  logic [2:0]      req;
  logic            wr_ok;
  logic            sel_pend, sel_en;
  logic [31:0]     rd_mux;

`ifdef GPIO_IRQ_SYNC_EN
  logic [W0-1:0] g0_m;
  logic [W1-1:0] g1_m;
  logic [WE-1:0] ge_m;

  // Two-flop synchronizer on every pin for inputs asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g0_m <= '0; g1_m <= '0; ge_m <= '0;
      g0_s <= '0; g1_s <= '0; ge_s <= '0;
    end else begin
      g0_m <= gpio0_i; g1_m <= gpio1_i; ge_m <= gpioe_i;
      g0_s <= g0_m;    g1_s <= g1_m;    ge_s <= ge_m;
    end
  end
`else
  assign g0_s = gpio0_i;
  assign g1_s = gpio1_i;
  assign ge_s = gpioe_i;
`endif

  // Previous pin level, used to spot 0->1 transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g0_q <= '0; g1_q <= '0; ge_q <= '0;
    end else begin
      g0_q <= g0_s; g1_q <= g1_s; ge_q <= ge_s;
    end
  end

  assign edge0 = g0_s & ~g0_q;
  assign edge1 = g1_s & ~g1_q;
  assign edgee = ge_s & ~ge_q;

  // A read wins over a simultaneous write, so the write is dropped.
  assign wr_ok = avs_write & ~avs_read;

  // Clear-on-read clears exactly the bits being returned; write-1-to-clear otherwise.
  always_comb begin
    clr0 = '0;
    clr1 = '0;
    clre = '0;
    if (avs_read) begin
      case (avs_address)
        2'd0:    clr0 = pend0;
        2'd1:    clr1 = pend1;
        2'd2:    clre = pende;
        default: ;
      endcase
    end else if (wr_ok) begin
      case (avs_address)
        2'd0:    clr0 = avs_writedata[W0-1:0];
        2'd1:    clr1 = avs_writedata[W1-1:0];
        2'd2:    clre = avs_writedata[WE-1:0];
        default: ;
      endcase
    end
  end

  // Pending bits: a new edge in the same cycle as a clear keeps the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend0 <= '0; pend1 <= '0; pende <= '0;
    end else begin
      pend0 <= (pend0 & ~clr0) | edge0;
      pend1 <= (pend1 & ~clr1) | edge1;
      pende <= (pende & ~clre) | edgee;
    end
  end

  // Bank enable register; disabled banks still latch, they just never win arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      enable <= 3'b111;
    else if (wr_ok && avs_address == 2'd3)
      enable <= avs_writedata[2:0];
  end

  // Register map read mux, zero-extended to 32 bits.
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      2'd0:    rd_mux[W0-1:0] = pend0;
      2'd1:    rd_mux[W1-1:0] = pend1;
      2'd2:    rd_mux[WE-1:0] = pende;
      default: rd_mux[2:0]    = enable;
    endcase
  end

  // Read data is returned the cycle after the strobe and held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      avs_readdata <= '0;
    else if (avs_read)
      avs_readdata <= rd_mux;
  end

  assign req = {(|pende) & enable[2], (|pend1) & enable[1], (|pend0) & enable[0]};

  // Pending/enable status of the bank currently owning the irq line.
  always_comb begin
    sel_pend = 1'b0;
    sel_en   = 1'b0;
    case (sel)
      2'd0:    begin sel_pend = |pend0; sel_en = enable[0]; end
      2'd1:    begin sel_pend = |pend1; sel_en = enable[1]; end
      2'd2:    begin sel_pend = |pende; sel_en = enable[2]; end
      default: ;
    endcase
  end

  // FSM state, owning bank and issued id.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= 2'd0;
      irq_id_o <= 5'd0;
    end else begin
      state    <= state_d;
      sel      <= sel_d;
      irq_id_o <= id_d;
    end
  end

  // Next-state: fixed-priority pick in IDLE, wait for matching ack in REQ, wait for ISR clear in SERVICE.
  always_comb begin
    state_d = state;
    sel_d   = sel;
    id_d    = irq_id_o;
    case (state)
      IDLE: begin
        if (req[0]) begin
          state_d = REQ; sel_d = 2'd0; id_d = ID_B0;
        end else if (req[1]) begin
          state_d = REQ; sel_d = 2'd1; id_d = ID_B1;
        end else if (req[2]) begin
          state_d = REQ; sel_d = 2'd2; id_d = ID_BE;
        end
      end
      REQ: begin
        if (irq_ack_i && irq_ack_id_i == irq_id_o)
          state_d = SERVICE;
        else if (!sel_en)
          state_d = IDLE;
      end
      SERVICE: begin
        if (!sel_pend)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign irq_o = (state == REQ);

endmodule

// File: tb/tb_gpio_irq_arbiter.sv
module tb_gpio_irq_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] gpio0, gpio1;
  logic [7:0]  gpioe;
  logic        irq_o;
  logic [4:0]  irq_id_o;
  logic        irq_ack;
  logic [4:0]  irq_ack_id;
  logic [1:0]  addr;
  logic        rd, wr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: per-bank pending words, level history, enable,
  // owning bank (-1 = line free) and whether the owner has been acked.
  logic [31:0] m_pend [3];
  logic [31:0] m_prev [3];
  logic [2:0]  m_en;
  int          m_owner;
  bit          m_acked;
  logic [31:0] m_rdata;
  bit          rd_chk;
  logic [31:0] mask [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};
  int          ids  [3] = '{3, 4, 5};

  gpio_irq_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .gpio0_i(gpio0), .gpio1_i(gpio1), .gpioe_i(gpioe),
    .irq_o(irq_o), .irq_id_o(irq_id_o),
    .irq_ack_i(irq_ack), .irq_ack_id_i(irq_ack_id),
    .avs_address(addr), .avs_read(rd), .avs_write(wr),
    .avs_writedata(wdata), .avs_readdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      m_pend[b] = '0;
      m_prev[b] = '0;
    end
    m_en    = 3'b111;
    m_owner = -1;
    m_acked = 0;
    rd_chk  = 0;
  endtask

  // One clock of the specification's rules, using the inputs present at the edge.
  task automatic model_step();
    logic [31:0] g [3];
    logic [31:0] e [3];
    logic [31:0] c [3];
    g[0] = gpio0;
    g[1] = gpio1;
    g[2] = {24'h0, gpioe};
    for (int b = 0; b < 3; b++) begin
      e[b] = g[b] & ~m_prev[b];
      c[b] = '0;
      if (rd && int'(addr) == b)       c[b] = m_pend[b];
      else if (wr && !rd && int'(addr) == b) c[b] = wdata & mask[b];
    end
    rd_chk = rd;
    if (rd) m_rdata = (addr == 2'd3) ? {29'h0, m_en} : m_pend[addr];
    if (m_owner < 0) begin
      for (int b = 2; b >= 0; b--)
        if (m_pend[b] != 0 && m_en[b]) m_owner = b;
      m_acked = 0;
    end else if (!m_acked) begin
      if (irq_ack && int'(irq_ack_id) == ids[m_owner]) m_acked = 1;
      else if (!m_en[m_owner]) m_owner = -1;
    end else if (m_pend[m_owner] == 0) begin
      m_owner = -1;
    end
    for (int b = 0; b < 3; b++) begin
      m_pend[b] = (m_pend[b] & ~c[b]) | e[b];
      m_prev[b] = g[b];
    end
    if (wr && !rd && addr == 2'd3) m_en = wdata[2:0];
  endtask

  // Advance one clock, step the model, compare at the falling edge, drop strobes.
  task automatic tick();
    bit m_irq;
    @(posedge clk);
    model_step();
    @(negedge clk);
    m_irq = (m_owner >= 0) && !m_acked;
    chk("irq_o", {31'h0, irq_o}, {31'h0, m_irq});
    if (m_irq) chk("irq_id_o", {27'h0, irq_id_o}, ids[m_owner]);
    if (rd_chk) chk("avs_readdata", rdata, m_rdata);
    rd = 0; wr = 0; irq_ack = 0; irq_ack_id = 0;
  endtask

  task automatic do_read(input logic [1:0] a);
    rd = 1; addr = a;
    tick();
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    wr = 1; addr = a; wdata = d;
    tick();
  endtask

  task automatic do_ack(input logic [4:0] id);
    irq_ack = 1; irq_ack_id = id;
    tick();
  endtask

  initial begin
    rst_n = 0;
    gpio0 = 0; gpio1 = 0; gpioe = 0;
    irq_ack = 0; irq_ack_id = 0;
    addr = 0; rd = 0; wr = 0; wdata = 0;
    model_reset();
    #3;
    chk("reset irq_o", {31'h0, irq_o}, 32'h0);
    chk("reset irq_id_o", {27'h0, irq_id_o}, 32'h0);
    chk("reset readdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1;

    // 1) bank 0 pin 5
    gpio0 = 32'h20; tick();
    gpio0 = 0;      tick();
    chk("t1 irq", {31'h0, irq_o}, 32'h1);
    chk("t1 id", {27'h0, irq_id_o}, 32'd3);
    do_ack(5'd3);
    chk("t1 irq after ack", {31'h0, irq_o}, 32'h0);
    do_read(2'd0);
    chk("t1 pend0", rdata, 32'h0000_0020);
    tick();
    chk("t1 idle", {31'h0, irq_o}, 32'h0);

    // 2) bank E pin 7, clear-on-read
    gpioe = 8'h80; tick();
    gpioe = 0;     tick();
    chk("t2 id", {27'h0, irq_id_o}, 32'd5);
    do_ack(5'd5);
    do_read(2'd2);
    chk("t2 pende", rdata, 32'h0000_0080);
    do_read(2'd2);
    chk("t2 pende again", rdata, 32'h0);
    tick();

    // 3) bank 1 and bank E together
    gpio1 = 32'h1; gpioe = 8'h1; tick();
    gpio1 = 0;     gpioe = 0;    tick();
    chk("t3 first id", {27'h0, irq_id_o}, 32'd4);
    do_ack(5'd4);
    do_read(2'd1);
    chk("t3 pend1", rdata, 32'h1);
    tick();
    chk("t3 gap", {31'h0, irq_o}, 32'h0);
    tick();
    chk("t3 second irq", {31'h0, irq_o}, 32'h1);
    chk("t3 second id", {27'h0, irq_id_o}, 32'd5);
    do_ack(5'd5);
    do_read(2'd2);
    chk("t3 pende", rdata, 32'h1);
    tick();

    // 4) bank 1 masked, then unmasked
    do_write(2'd3, 32'h5);
    gpio1 = 32'h8000_0000; tick();
    gpio1 = 0; tick(); tick(); tick();
    chk("t4 masked", {31'h0, irq_o}, 32'h0);
    do_write(2'd3, 32'hFFFF_FFFF);
    do_read(2'd3);
    chk("t4 enable rd", rdata, 32'h7);
    chk("t4 unmasked irq", {31'h0, irq_o}, 32'h1);
    chk("t4 unmasked id", {27'h0, irq_id_o}, 32'd4);
    do_ack(5'd4);
    do_read(2'd1);
    chk("t4 pend1", rdata, 32'h8000_0000);
    tick();

    // 5) wrong-id ack ignored, then reset mid-REQ
    gpio0 = 32'h1; tick();
    gpio0 = 0;     tick();
    do_ack(5'd7);
    chk("t5 wrong ack", {31'h0, irq_o}, 32'h1);
    rst_n = 0;
    #1;
    chk("t5 async irq drop", {31'h0, irq_o}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    do_read(2'd0);
    chk("t5 pend0", rdata, 32'h0);
    do_read(2'd1);
    chk("t5 pend1", rdata, 32'h0);
    do_read(2'd2);
    chk("t5 pende", rdata, 32'h0);

    // 6) clear-on-read racing a new edge on an already-pending bit
    do_write(2'd3, 32'h0);
    gpio0 = 32'h2; tick();
    gpio0 = 32'h4; tick();
    gpio0 = 32'h0; tick();
    gpio0 = 32'h4; do_read(2'd0);
    chk("t6 old bits", rdata, 32'h6);
    gpio0 = 32'h0; do_read(2'd0);
    chk("t6 bit2 kept", rdata, 32'h4);
    do_write(2'd3, 32'h7);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      gpio0 ^= $urandom & $urandom & $urandom & $urandom;
      gpio1 ^= $urandom & $urandom & $urandom & $urandom;
      gpioe ^= 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 5) == 0) begin
        rd = 1; addr = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 11) == 0) begin
        wr = 1; addr = 2'($urandom_range(0, 3)); wdata = $urandom;
        if (addr == 2'd3 && $urandom_range(0, 2) != 0) wdata[2:0] = 3'b111;
      end
      if (m_owner >= 0 && !m_acked && $urandom_range(0, 3) == 0) begin
        irq_ack = 1;
        irq_ack_id = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'(ids[m_owner]);
      end else if ($urandom_range(0, 19) == 0) begin
        irq_ack = 1;
        irq_ack_id = 5'($urandom_range(0, 31));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
